// File: rtl/control_unit.sv
// Multicycle control FSM for the 16-bit processor: fetches instructions into IR and
// sequences register-bank, ALU and memory-interface control for each instruction.
module control_unit #(
   parameter int DATA_WIDTH = 16,
   parameter int PC_INDEX   = 7
) (
   input  logic                  p_Clock,
   input  logic                  p_Resetn,
   input  logic                  p_Run,
   input  logic [DATA_WIDTH-1:0] p_MemData,
   input  logic                  p_GNotZero,
   output logic                  p_IncPC,
   output logic                  p_EnableWrite,
   output logic [2:0]            p_WriteAddr,
   output logic [2:0]            p_ReadAddr1,
   output logic [2:0]            p_ReadAddr2,
   output logic                  p_AddrLoad,
   output logic                  p_DoutLoad,
   output logic                  p_MemWrite,
   output logic                  p_GLoad,
   output logic                  p_ALUSub,
   output logic [1:0]            p_WBSel,
   output logic                  p_Done,
   output logic [DATA_WIDTH-1:0] p_IR
);

   localparam logic [2:0] PC_ADDR = 3'(PC_INDEX);

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_LD   = 3'b100;
   localparam logic [2:0] OP_ST   = 3'b101;
   localparam logic [2:0] OP_MVNZ = 3'b110;
   localparam logic [2:0] OP_NOP  = 3'b111;

   localparam logic [1:0] WB_DOUT2 = 2'b00;
   localparam logic [1:0] WB_MEM   = 2'b01;
   localparam logic [1:0] WB_G     = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_MWAIT  = 3'd2,
      S_LOADIR = 3'd3,
      S_EX1    = 3'd4,
      S_EX2    = 3'd5,
      S_EX3    = 3'd6
   } state_t;

   state_t                  state, state_next;
   logic [DATA_WIDTH-1:0]   ir;
   logic [2:0]              opcode, rx, ry;
   logic                    last_cycle;

   assign opcode = ir[DATA_WIDTH-1:DATA_WIDTH-3];
   assign rx     = ir[DATA_WIDTH-4:DATA_WIDTH-6];
   assign ry     = ir[DATA_WIDTH-7:DATA_WIDTH-9];
   assign p_IR   = ir;

   // State and instruction register; IR is written only in LOADIR
   always_ff @(posedge p_Clock or negedge p_Resetn) begin
      if (!p_Resetn) begin
         state <= S_IDLE;
         ir    <= '0;
      end else begin
         state <= state_next;
         if (state == S_LOADIR)
            ir <= p_MemData;
      end
   end

   // Instruction length is fixed by opcode: 1, 2 or 3 execute cycles
   always_comb begin
      last_cycle = 1'b0;
      case (state)
         S_EX1: last_cycle = (opcode == OP_MV) || (opcode == OP_MVNZ) || (opcode == OP_NOP);
         S_EX2: last_cycle = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_ST);
         S_EX3: last_cycle = 1'b1;
         default: last_cycle = 1'b0;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   state_next = p_Run ? S_FETCH : S_IDLE;
         S_FETCH:  state_next = S_MWAIT;
         S_MWAIT:  state_next = S_LOADIR;
         S_LOADIR: state_next = S_EX1;
         S_EX1:    state_next = last_cycle ? (p_Run ? S_FETCH : S_IDLE) : S_EX2;
         S_EX2:    state_next = last_cycle ? (p_Run ? S_FETCH : S_IDLE) : S_EX3;
         S_EX3:    state_next = p_Run ? S_FETCH : S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_comb begin
      p_IncPC       = 1'b0;
      p_EnableWrite = 1'b0;
      p_WriteAddr   = 3'd0;
      p_ReadAddr1   = 3'd0;
      p_ReadAddr2   = 3'd0;
      p_AddrLoad    = 1'b0;
      p_DoutLoad    = 1'b0;
      p_MemWrite    = 1'b0;
      p_GLoad       = 1'b0;
      p_ALUSub      = 1'b0;
      p_WBSel       = WB_DOUT2;
      p_Done        = 1'b0;
      case (state)
         S_FETCH: begin
            p_ReadAddr1 = PC_ADDR;
            p_AddrLoad  = 1'b1;
            p_IncPC     = 1'b1;
         end
         S_EX1: begin
            case (opcode)
               OP_MV, OP_MVNZ: begin
                  p_ReadAddr2   = ry;
                  p_WBSel       = WB_DOUT2;
                  p_WriteAddr   = rx;
                  p_EnableWrite = (opcode == OP_MV) ? 1'b1 : p_GNotZero;
                  p_Done        = 1'b1;
               end
               OP_MVI: begin
                  // Immediate sits at the word after the instruction; PC points there now
                  p_ReadAddr1 = PC_ADDR;
                  p_AddrLoad  = 1'b1;
                  p_IncPC     = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  p_ReadAddr1 = rx;
                  p_ReadAddr2 = ry;
                  p_GLoad     = 1'b1;
                  p_ALUSub    = opcode[0];
               end
               OP_LD: begin
                  p_ReadAddr1 = ry;
                  p_AddrLoad  = 1'b1;
               end
               OP_ST: begin
                  p_ReadAddr1 = ry;
                  p_AddrLoad  = 1'b1;
                  p_ReadAddr2 = rx;
                  p_DoutLoad  = 1'b1;
               end
               OP_NOP: p_Done = 1'b1;
               default: p_Done = 1'b0;
            endcase
         end
         S_EX2: begin
            case (opcode)
               OP_ADD, OP_SUB: begin
                  p_WBSel       = WB_G;
                  p_WriteAddr   = rx;
                  p_EnableWrite = 1'b1;
                  p_Done        = 1'b1;
               end
               OP_ST: begin
                  p_MemWrite = 1'b1;
                  p_Done     = 1'b1;
               end
               default: p_Done = 1'b0;
            endcase
         end
         S_EX3: begin
            if (opcode == OP_MVI || opcode == OP_LD) begin
               p_WBSel       = WB_MEM;
               p_WriteAddr   = rx;
               p_EnableWrite = 1'b1;
               p_Done        = 1'b1;
            end
         end
         default: p_Done = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks instruction sequences cycle by cycle and
// compares the packed control word against hand-derived values.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic [15:0] mem_data;
   logic        g_nz;
   logic        inc_pc, en_wr, a_load, d_load, mem_wr, g_load, alu_sub, done;
   logic [2:0]  w_addr, r_addr1, r_addr2;
   logic [1:0]  wb_sel;
   logic [15:0] ir;

   int total = 0;
   int bad   = 0;

   control_unit #(.DATA_WIDTH(16), .PC_INDEX(7)) dut (
      .p_Clock(clk), .p_Resetn(rst_n), .p_Run(run), .p_MemData(mem_data),
      .p_GNotZero(g_nz), .p_IncPC(inc_pc), .p_EnableWrite(en_wr),
      .p_WriteAddr(w_addr), .p_ReadAddr1(r_addr1), .p_ReadAddr2(r_addr2),
      .p_AddrLoad(a_load), .p_DoutLoad(d_load), .p_MemWrite(mem_wr),
      .p_GLoad(g_load), .p_ALUSub(alu_sub), .p_WBSel(wb_sel), .p_Done(done),
      .p_IR(ir)
   );

   always #5 clk = ~clk;

   // Packed order: inc en waddr ra1 ra2 aload dload mwr gload sub wbsel done (19 bits)
   function automatic logic [18:0] cw(input logic inc, input logic en, input logic [2:0] wa,
                                      input logic [2:0] r1, input logic [2:0] r2,
                                      input logic al, input logic dl, input logic mw,
                                      input logic gl, input logic sb, input logic [1:0] wb,
                                      input logic dn);
      return {inc, en, wa, r1, r2, al, dl, mw, gl, sb, wb, dn};
   endfunction

   function automatic logic [18:0] obs_cw();
      return {inc_pc, en_wr, w_addr, r_addr1, r_addr2, a_load, d_load, mem_wr,
              g_load, alu_sub, wb_sel, done};
   endfunction

   task automatic check_cw(input string tag, input logic [18:0] exp);
      logic [18:0] o;
      o = obs_cw();
      total++;
      assert (o === exp) else begin
         bad++;
         $error("FAIL %s observed=%05h expected=%05h", tag, o, exp);
      end
   endtask

   task automatic check_ir(input string tag, input logic [15:0] exp);
      total++;
      assert (ir === exp) else begin
         bad++;
         $error("FAIL %s observed=%04h expected=%04h", tag, ir, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [18:0] ZERO = 19'd0;

   // Enters at IDLE/final state; checks FETCH, MWAIT, LOADIR and presents the instruction
   task automatic fetch(input string tag, input logic [15:0] instr);
      tick();
      check_cw({tag, "_fetch"}, cw(1, 0, 0, 7, 0, 1, 0, 0, 0, 0, 2'b00, 0));
      tick();
      check_cw({tag, "_mwait"}, ZERO);
      mem_data = 16'hFFFF;
      tick();
      mem_data = instr;
      tick();
      check_ir({tag, "_ir"}, instr);
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; mem_data = 16'h0; g_nz = 1'b0;
      #12;
      check_cw("reset_outputs", ZERO);
      check_ir("reset_ir", 16'h0000);
      rst_n = 1'b1;
      tick();
      check_cw("idle_norun", ZERO);
      run = 1'b1;

      // mvi R0,#5
      fetch("mvi0", 16'h2000);
      check_cw("mvi0_ex1", cw(1, 0, 0, 7, 0, 1, 0, 0, 0, 0, 2'b00, 0));
      tick(); check_cw("mvi0_ex2", ZERO);
      tick(); check_cw("mvi0_ex3", cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1));

      // mvi R1,#3
      fetch("mvi1", 16'h2400);
      tick(); tick();
      check_cw("mvi1_ex3", cw(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1));

      // add R0,R1
      fetch("add", 16'h4080);
      check_cw("add_ex1", cw(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 2'b00, 0));
      tick(); check_cw("add_ex2", cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1));

      // sub R2,R3
      fetch("sub", 16'h6980);
      check_cw("sub_ex1", cw(0, 0, 0, 2, 3, 0, 0, 0, 1, 1, 2'b00, 0));
      tick(); check_cw("sub_ex2", cw(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1));

      // mvnz R4,R5 with G zero, then nonzero
      g_nz = 1'b0;
      fetch("mvnz0", 16'hD280);
      check_cw("mvnz0_ex1", cw(0, 0, 4, 0, 5, 0, 0, 0, 0, 0, 2'b00, 1));
      g_nz = 1'b1;
      fetch("mvnz1", 16'hD280);
      check_cw("mvnz1_ex1", cw(0, 1, 4, 0, 5, 0, 0, 0, 0, 0, 2'b00, 1));

      // ld R6,[R1]
      fetch("ld", 16'h9880);
      check_cw("ld_ex1", cw(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0));
      tick(); check_cw("ld_ex2", ZERO);
      tick(); check_cw("ld_ex3", cw(0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1));

      // st R6,[R2]
      fetch("st", 16'hB900);
      check_cw("st_ex1", cw(0, 0, 0, 2, 6, 1, 1, 0, 0, 0, 2'b00, 0));
      tick(); check_cw("st_ex2", cw(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 1));

      // nop
      fetch("nop", 16'hE000);
      check_cw("nop_ex1", cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1));

      // mv R7,R0 (jump) with run dropped in its final cycle
      fetch("mv", 16'h1C00);
      run = 1'b0;
      check_cw("mv_ex1", cw(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
      tick(); check_cw("mv_idle", ZERO);
      mem_data = 16'h5555;
      tick(); check_cw("mv_idle_hold", ZERO);
      check_ir("ir_hold_idle", 16'h1C00);
      run = 1'b1;

      // add R0,R1 with async reset asserted in EX2
      fetch("add2", 16'h4080);
      tick();
      check_cw("add2_ex2", cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1));
      #2 rst_n = 1'b0;
      #1;
      check_cw("midreset_outputs", ZERO);
      check_ir("midreset_ir", 16'h0000);
      run = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();
      check_cw("post_reset_idle", ZERO);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
